// File: rtl/audio_gain_path.sv
// Per-channel gain stage between I2S receive and transmit codecs: capture, multiply,
// round-half-up, saturate, then buffer per channel for the transmitter to drain in order.
module audio_gain_path #(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned GAIN_WIDTH = 16,
  parameter int unsigned GAIN_FRAC  = 12,
  parameter bit          PAD_SIGN   = 1'b0,
  localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  lmmi_clk_i,
  input  logic                  reset_n_i,
  input  logic                  adc_valid_i,
  input  logic [31:0]           adc_data_i,
  input  logic                  sync_i,
  input  logic                  dac_request_i,
  output logic [31:0]           dac_data_o,
  input  logic                  cfg_wr_i,
  input  logic [CH_W-1:0]       cfg_ch_i,
  input  logic [GAIN_WIDTH-1:0] cfg_gain_i,
  input  logic                  cfg_mute_i,
  input  logic                  sat_clr_i,
  output logic [NUM_CH-1:0]     sat_flag_o,
  output logic                  out_valid_o
);

  localparam int unsigned PW = DATA_WIDTH + GAIN_WIDTH;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);
  localparam logic signed [GAIN_WIDTH-1:0] UNITY = GAIN_WIDTH'(1) << GAIN_FRAC;
  localparam logic signed [PW-1:0] ROUND_K = PW'(1) << (GAIN_FRAC - 1);
  localparam logic signed [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] c);
    return (c == LAST_CH) ? '0 : c + CH_W'(1);
  endfunction

  logic [CH_W-1:0]              wr_ch, rd_ch, cap_ch_c;
  logic signed [GAIN_WIDTH-1:0] gain_q [NUM_CH];
  logic [NUM_CH-1:0]            mute_q;

  logic                         v0_q, mute0_q;
  logic [CH_W-1:0]              ch0_q;
  logic signed [DATA_WIDTH-1:0] smp_q;
  logic signed [GAIN_WIDTH-1:0] gain0_q;

  logic                         v1_q, mute1_q;
  logic [CH_W-1:0]              ch1_q;
  logic signed [PW-1:0]         prod_q;

  logic signed [PW-1:0]         sum_c, shr_c;
  logic signed [DATA_WIDTH-1:0] res_c;
  logic                         clip_c;
  logic [NUM_CH-1:0]            sat_set_c;
  logic signed [DATA_WIDTH-1:0] out_buf [NUM_CH];
  logic signed [DATA_WIDTH-1:0] rd_word_c;
  logic                         unused_adc_bits;

  assign unused_adc_bits = ^adc_data_i[31:DATA_WIDTH];

  // A sync in the same cycle as a valid tags that sample as channel 0.
  assign cap_ch_c = sync_i ? '0 : wr_ch;

  // Channel counters and gain/mute configuration.
  always_ff @(posedge lmmi_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ch  <= '0;
      rd_ch  <= '0;
      mute_q <= '0;
      for (int i = 0; i < int'(NUM_CH); i++) gain_q[i] <= UNITY;
    end else begin
      if (sync_i)             wr_ch <= '0;
      else if (adc_valid_i)   wr_ch <= next_ch(wr_ch);
      if (sync_i)             rd_ch <= '0;
      else if (dac_request_i) rd_ch <= next_ch(rd_ch);
      if (cfg_wr_i && (32'(cfg_ch_i) < NUM_CH)) begin
        gain_q[cfg_ch_i] <= cfg_gain_i;
        mute_q[cfg_ch_i] <= cfg_mute_i;
      end
    end
  end

  // Capture and multiply stages; gain/mute are frozen with the sample.
  always_ff @(posedge lmmi_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      v0_q    <= 1'b0;
      ch0_q   <= '0;
      smp_q   <= '0;
      gain0_q <= '0;
      mute0_q <= 1'b0;
      v1_q    <= 1'b0;
      ch1_q   <= '0;
      mute1_q <= 1'b0;
      prod_q  <= '0;
    end else begin
      v0_q <= adc_valid_i;
      if (adc_valid_i) begin
        ch0_q   <= cap_ch_c;
        smp_q   <= adc_data_i[DATA_WIDTH-1:0];
        gain0_q <= gain_q[cap_ch_c];
        mute0_q <= mute_q[cap_ch_c];
      end
      v1_q <= v0_q;
      if (v0_q) begin
        ch1_q   <= ch0_q;
        mute1_q <= mute0_q;
        prod_q  <= PW'(smp_q) * PW'(gain0_q);
      end
    end
  end

  assign sum_c = prod_q + ROUND_K;
  assign shr_c = sum_c >>> GAIN_FRAC;

  // Round-half-up result clamped to the sample range; mute forces a clean zero.
  always_comb begin
    clip_c    = 1'b0;
    res_c     = shr_c[DATA_WIDTH-1:0];
    sat_set_c = '0;
    if (shr_c > PW'(SAT_MAX)) begin
      res_c  = SAT_MAX;
      clip_c = 1'b1;
    end else if (shr_c < PW'(SAT_MIN)) begin
      res_c  = SAT_MIN;
      clip_c = 1'b1;
    end
    if (mute1_q) begin
      res_c  = '0;
      clip_c = 1'b0;
    end
    if (v1_q && clip_c) sat_set_c[ch1_q] = 1'b1;
  end

  // Output buffer and sticky flags; a new clip outranks a simultaneous clear.
  always_ff @(posedge lmmi_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      out_valid_o <= 1'b0;
      sat_flag_o  <= '0;
      for (int i = 0; i < int'(NUM_CH); i++) out_buf[i] <= '0;
    end else begin
      out_valid_o <= v1_q;
      if (v1_q) out_buf[ch1_q] <= res_c;
      sat_flag_o <= (sat_clr_i ? '0 : sat_flag_o) | sat_set_c;
    end
  end

  assign rd_word_c  = out_buf[rd_ch];
  assign dac_data_o = PAD_SIGN ? 32'(rd_word_c) : 32'($unsigned(rd_word_c));

endmodule

// File: tb/tb_audio_gain_path.sv
// Bench for audio_gain_path: directed scenarios plus random traffic against an
// arithmetic reference model of gain, rounding, saturation and channel buffering.
module tb_audio_gain_path;

  localparam int DW  = 24;
  localparam int NCH = 2;
  localparam int GW  = 16;
  localparam int GF  = 12;

  logic          clk;
  logic          rst_n;
  logic          adc_valid;
  logic [31:0]   adc_data;
  logic          sync;
  logic          req;
  logic [31:0]   dac_data;
  logic          cfg_wr;
  logic          cfg_ch;
  logic [GW-1:0] cfg_gain;
  logic          cfg_mute;
  logic          sat_clr;
  logic [NCH-1:0] sat_flag;
  logic          out_valid;

  int errors;
  int checks;

  audio_gain_path #(
    .DATA_WIDTH(DW), .NUM_CH(NCH), .GAIN_WIDTH(GW), .GAIN_FRAC(GF), .PAD_SIGN(1'b0)
  ) dut (
    .lmmi_clk_i   (clk),
    .reset_n_i    (rst_n),
    .adc_valid_i  (adc_valid),
    .adc_data_i   (adc_data),
    .sync_i       (sync),
    .dac_request_i(req),
    .dac_data_o   (dac_data),
    .cfg_wr_i     (cfg_wr),
    .cfg_ch_i     (cfg_ch),
    .cfg_gain_i   (cfg_gain),
    .cfg_mute_i   (cfg_mute),
    .sat_clr_i    (sat_clr),
    .sat_flag_o   (sat_flag),
    .out_valid_o  (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  typedef struct {
    int     due;
    int     ch;
    longint val;
    bit     clip;
  } pend_t;

  pend_t          pq[$];
  longint         ref_buf[NCH];
  logic [GW-1:0]  ref_gain[NCH];
  bit             ref_mute[NCH];
  int             ref_wr, ref_rd, cyc;
  bit [NCH-1:0]   ref_flags;
  bit             exp_ov;
  logic [31:0]    consumed;

  function automatic void calc(input logic [31:0] d, input logic [GW-1:0] g, input bit m,
                               output longint val, output bit clip);
    longint s, k, r, maxv, minv;
    s    = longint'($signed(d[DW-1:0]));
    k    = longint'($signed(g));
    maxv = (longint'(1) << (DW - 1)) - 1;
    minv = -(longint'(1) << (DW - 1));
    r    = (s * k + (longint'(1) << (GF - 1))) >>> GF;
    clip = 1'b0;
    if (r > maxv) begin r = maxv; clip = 1'b1; end
    else if (r < minv) begin r = minv; clip = 1'b1; end
    if (m) begin r = 0; clip = 1'b0; end
    val = r;
  endfunction

  function automatic logic [31:0] exp_dac();
    logic [31:0] mask;
    mask = (32'd1 << DW) - 32'd1;
    return 32'(ref_buf[ref_rd]) & mask;
  endfunction

  task automatic model_reset();
    pq.delete();
    for (int i = 0; i < NCH; i++) begin
      ref_buf[i]  = 0;
      ref_gain[i] = GW'(1 << GF);
      ref_mute[i] = 1'b0;
    end
    ref_wr = 0; ref_rd = 0; cyc = 0; ref_flags = '0; exp_ov = 1'b0;
  endtask

  task automatic clear_inputs();
    adc_valid = 1'b0; adc_data = '0; sync = 1'b0; req = 1'b0;
    cfg_wr = 1'b0; cfg_ch = 1'b0; cfg_gain = '0; cfg_mute = 1'b0; sat_clr = 1'b0;
  endtask

  // One clock: record what the transmitter consumes, advance the model, release strobes.
  task automatic tick();
    int ch;
    longint v;
    bit c;
    bit [NCH-1:0] set;
    consumed = dac_data;
    @(posedge clk);
    cyc++;
    set = '0;
    exp_ov = 1'b0;
    while (pq.size() > 0 && pq[0].due == cyc) begin
      ref_buf[pq[0].ch] = pq[0].val;
      if (pq[0].clip) set[pq[0].ch] = 1'b1;
      exp_ov = 1'b1;
      void'(pq.pop_front());
    end
    if (adc_valid) begin
      ch = sync ? 0 : ref_wr;
      calc(adc_data, ref_gain[ch], ref_mute[ch], v, c);
      pq.push_back('{cyc + 2, ch, v, c});
    end
    if (sync) ref_wr = 0;
    else if (adc_valid) ref_wr = (ref_wr + 1) % NCH;
    if (sync) ref_rd = 0;
    else if (req) ref_rd = (ref_rd + 1) % NCH;
    if (cfg_wr) begin
      ref_gain[cfg_ch] = cfg_gain;
      ref_mute[cfg_ch] = cfg_mute;
    end
    ref_flags = (sat_clr ? '0 : ref_flags) | set;
    #1;
    clear_inputs();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (dac_data !== 32'h0) begin errors++; $display("FAIL reset_dac: got %h exp %h", dac_data, 32'h0); end
    checks++; if (sat_flag !== '0) begin errors++; $display("FAIL reset_sat: got %b exp 00", sat_flag); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_ov: got %b exp 0", out_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++; if (dac_data !== 32'h0) begin errors++; $display("FAIL post_reset_dac: got %h exp %h", dac_data, 32'h0); end
  endtask

  task automatic test_unity();
    adc_valid = 1'b1; adc_data = 32'h0010_0000; tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL unity_lat1: got %b exp 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL unity_lat2: got %b exp 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL unity_ov: got %b exp 1", out_valid); end
    checks++; if (dac_data !== 32'h0010_0000) begin errors++; $display("FAIL unity_dac: got %h exp %h", dac_data, 32'h0010_0000); end
    checks++; if (sat_flag !== 2'b00) begin errors++; $display("FAIL unity_sat: got %b exp 00", sat_flag); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL unity_pulse: got %b exp 0", out_valid); end
  endtask

  task automatic test_gain_scale();
    sync = 1'b1; cfg_wr = 1'b1; cfg_ch = 1'b0; cfg_gain = 16'h0080; tick();
    cfg_wr = 1'b1; cfg_ch = 1'b1; cfg_gain = 16'h1000; tick();
    adc_valid = 1'b1; adc_data = 32'h0010_0000; tick();
    adc_valid = 1'b1; adc_data = 32'h00F0_0000; tick();
    tick(); tick();
    checks++; if (dac_data !== 32'h0000_8000) begin errors++; $display("FAIL scale_ch0: got %h exp %h", dac_data, 32'h0000_8000); end
    req = 1'b1; tick();
    checks++; if (dac_data !== 32'h00F0_0000) begin errors++; $display("FAIL scale_ch1: got %h exp %h", dac_data, 32'h00F0_0000); end
    req = 1'b1; tick();
    checks++; if (dac_data !== 32'h0000_8000) begin errors++; $display("FAIL scale_wrap: got %h exp %h", dac_data, 32'h0000_8000); end
  endtask

  task automatic test_saturation();
    sync = 1'b1; cfg_wr = 1'b1; cfg_ch = 1'b0; cfg_gain = 16'h2000; tick();
    adc_valid = 1'b1; adc_data = 32'h0050_0000; tick(); tick(); tick();
    checks++; if (dac_data !== 32'h007F_FFFF) begin errors++; $display("FAIL sat_pos: got %h exp %h", dac_data, 32'h007F_FFFF); end
    checks++; if (sat_flag !== 2'b01) begin errors++; $display("FAIL sat_pos_flag: got %b exp 01", sat_flag); end
    sync = 1'b1; adc_valid = 1'b1; adc_data = 32'h0080_0000; tick(); tick(); tick();
    checks++; if (dac_data !== 32'h0080_0000) begin errors++; $display("FAIL sat_neg: got %h exp %h", dac_data, 32'h0080_0000); end
    checks++; if (sat_flag !== 2'b01) begin errors++; $display("FAIL sat_neg_flag: got %b exp 01", sat_flag); end
    sat_clr = 1'b1; tick();
    checks++; if (sat_flag !== 2'b00) begin errors++; $display("FAIL sat_clear: got %b exp 00", sat_flag); end
    // clear coinciding with a fresh clip must leave the flag set
    sync = 1'b1; adc_valid = 1'b1; adc_data = 32'h0050_0000; tick(); tick();
    sat_clr = 1'b1; tick();
    checks++; if (sat_flag !== 2'b01) begin errors++; $display("FAIL sat_set_wins: got %b exp 01", sat_flag); end
    sat_clr = 1'b1; tick();
    checks++; if (sat_flag !== 2'b00) begin errors++; $display("FAIL sat_clear2: got %b exp 00", sat_flag); end
  endtask

  task automatic test_rounding();
    logic [31:0] din  [3] = '{32'h0000_0003, 32'h00FF_FFFD, 32'h0000_0001};
    logic [31:0] dexp [3] = '{32'h0000_0002, 32'h00FF_FFFF, 32'h0000_0001};
    sync = 1'b1; cfg_wr = 1'b1; cfg_ch = 1'b0; cfg_gain = 16'h0800; tick();
    for (int i = 0; i < 3; i++) begin
      sync = 1'b1; adc_valid = 1'b1; adc_data = din[i]; tick(); tick(); tick();
      checks++;
      if (dac_data !== dexp[i]) begin
        errors++; $display("FAIL round_%0d: got %h exp %h", i, dac_data, dexp[i]);
      end
    end
  endtask

  task automatic test_mute();
    sync = 1'b1; cfg_wr = 1'b1; cfg_ch = 1'b0; cfg_gain = 16'h1000; tick();
    cfg_wr = 1'b1; cfg_ch = 1'b1; cfg_gain = 16'h7FFF; cfg_mute = 1'b1; tick();
    adc_valid = 1'b1; adc_data = 32'h0012_3456; tick();
    adc_valid = 1'b1; adc_data = 32'h007F_FFFF; tick();
    tick(); tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mute_ov: got %b exp 1", out_valid); end
    checks++; if (dac_data !== 32'h0012_3456) begin errors++; $display("FAIL mute_ch0: got %h exp %h", dac_data, 32'h0012_3456); end
    req = 1'b1; tick();
    checks++; if (dac_data !== 32'h0) begin errors++; $display("FAIL mute_ch1: got %h exp %h", dac_data, 32'h0); end
    checks++; if (sat_flag !== 2'b00) begin errors++; $display("FAIL mute_sat: got %b exp 00", sat_flag); end
    cfg_wr = 1'b1; cfg_ch = 1'b1; cfg_gain = 16'h1000; tick();
  endtask

  task automatic test_channel_order();
    sync = 1'b1; tick();
    adc_valid = 1'b1; adc_data = 32'h0000_0AAA; tick();
    adc_valid = 1'b1; adc_data = 32'h0000_0BBB; tick();
    adc_valid = 1'b1; adc_data = 32'h0000_0CCC; sync = 1'b1; tick();
    tick(); tick();
    checks++; if (dac_data !== 32'h0000_0CCC) begin errors++; $display("FAIL order_c_ch0: got %h exp %h", dac_data, 32'h0000_0CCC); end
    req = 1'b1; tick();
    checks++; if (dac_data !== 32'h0000_0BBB) begin errors++; $display("FAIL order_b_ch1: got %h exp %h", dac_data, 32'h0000_0BBB); end
    req = 1'b1; tick();
    checks++; if (dac_data !== 32'h0000_0CCC) begin errors++; $display("FAIL order_wrap: got %h exp %h", dac_data, 32'h0000_0CCC); end
    adc_valid = 1'b1; adc_data = 32'h0000_0DDD; tick();
    tick();
    req = 1'b1; tick();
    checks++; if (consumed !== 32'h0000_0CCC) begin errors++; $display("FAIL order_same_cycle_old: got %h exp %h", consumed, 32'h0000_0CCC); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL order_same_cycle_ov: got %b exp 1", out_valid); end
    checks++; if (dac_data !== 32'h0000_0BBB) begin errors++; $display("FAIL order_after_read: got %h exp %h", dac_data, 32'h0000_0BBB); end
    req = 1'b1; tick();
    checks++; if (dac_data !== 32'h0000_0DDD) begin errors++; $display("FAIL order_new_value: got %h exp %h", dac_data, 32'h0000_0DDD); end
  endtask

  task automatic test_random();
    logic [31:0] e;
    for (int n = 0; n < 400; n++) begin
      adc_valid = 1'($urandom_range(0, 1));
      adc_data  = $urandom;
      sync      = ($urandom_range(0, 15) == 0);
      req       = ($urandom_range(0, 2) == 0);
      cfg_wr    = ($urandom_range(0, 7) == 0);
      cfg_ch    = 1'($urandom);
      cfg_gain  = 16'($urandom);
      cfg_mute  = ($urandom_range(0, 7) == 0);
      sat_clr   = ($urandom_range(0, 15) == 0);
      tick();
      e = exp_dac();
      checks++; if (dac_data !== e) begin errors++; $display("FAIL rand_dac@%0d: got %h exp %h", n, dac_data, e); end
      checks++; if (out_valid !== exp_ov) begin errors++; $display("FAIL rand_ov@%0d: got %b exp %b", n, out_valid, exp_ov); end
      checks++; if (sat_flag !== ref_flags) begin errors++; $display("FAIL rand_sat@%0d: got %b exp %b", n, sat_flag, ref_flags); end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_unity();
    test_gain_scale();
    test_saturation();
    test_rounding();
    test_mute();
    test_channel_order();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/audio_gain_path.md
Name: audio_gain_path

Overview:
Sample-processing stage between the I2S receive codec and the I2S transmit codec. It captures each received word and tags it with a channel index. Each sample gets a per-channel programmable signed gain, round-half-up and saturation, then is held in a per-channel output buffer. The transmit codec drains that buffer in channel order on its request strobe. This replaces the fixed arithmetic-shift attenuation with a configurable, multi-channel, overflow-safe path.

Parameters:
DATA_WIDTH, 24, signed sample width carried in bits [DATA_WIDTH-1:0] of the 32-bit codec words
NUM_CH, 2, channels per frame; channel index counts 0..NUM_CH-1 and wraps
GAIN_WIDTH, 16, signed gain coefficient width
GAIN_FRAC, 12, fractional bits of gain; unity = 1<<GAIN_FRAC
PAD_SIGN, 0, 0 = zero-fill dac_data_o[31:DATA_WIDTH]; 1 = sign-extend

Ports:
lmmi_clk_i  in  1  system clock
reset_n_i  in  1  asynchronous active-low reset
adc_valid_i  in  1  one-cycle strobe, adc_data_i valid (codec mem_rdwr_o)
adc_data_i  in  32  received word; bits above DATA_WIDTH ignored
sync_i  in  1  one-cycle strobe: next adc_valid_i is channel 0, next dac_request_i reads channel 0
dac_request_i  in  1  one-cycle strobe, transmit codec consumed dac_data_o
dac_data_o  out  32  buffered sample of current read channel, padded per PAD_SIGN
cfg_wr_i  in  1  write gain/mute for cfg_ch_i
cfg_ch_i  in  $clog2(NUM_CH) (min 1)  target channel
cfg_gain_i  in  GAIN_WIDTH  signed gain
cfg_mute_i  in  1  mute bit for target channel
sat_clr_i  in  1  clear all sticky saturation flags
sat_flag_o  out  NUM_CH  sticky per-channel saturation flag
out_valid_o  out  1  pulses when a processed sample is written to the buffer

Behaviour:
- Reset (async assert, sync release): gains = unity, mutes = 0, out buffers = 0, wr/rd channel counters = 0, pipeline valids = 0, sat_flag_o = 0, out_valid_o = 0, dac_data_o = 0.
- Capture (cycle N, adc_valid_i=1): latch sample and gain[wr_ch]; wr_ch increments, wrapping NUM_CH-1 -> 0.
- Stage 1 (N+1): signed product, width DATA_WIDTH+GAIN_WIDTH.
- Stage 2 (N+2): add 1<<(GAIN_FRAC-1), arithmetic shift right by GAIN_FRAC, saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - Result written to out_buf[ch]; out_valid_o=1 for one cycle.
  - If clipped, sat_flag_o[ch] set.
  - If mute[ch]=1 at capture, 0 is written and no saturation is flagged.
- Latency: adc_valid_i to buffer write = 2 cycles; fully pipelined, so back-to-back valids are accepted every cycle.
- Gain/mute sampled at capture: a cfg_wr_i in the same cycle as adc_valid_i for the same channel takes effect on the next sample of that channel.
- dac_data_o = padded out_buf[rd_ch], combinational from registers. On dac_request_i, rd_ch increments with wrap.
- Same-cycle buffer write and read of the same channel: the reader gets the old value; the new value appears at the next read of that channel.
- sync_i: wr_ch and rd_ch forced to 0. Takes priority over a simultaneous increment, and a simultaneous valid/request is treated as channel 0. In-flight pipeline samples keep their original tag.
- sat_clr_i and a simultaneous set on the same channel: set wins.
- No back-pressure. Unread buffer entries are overwritten by newer samples; buffer reads without new data repeat the last value.

Test Plan:
- Reset then unity gain, adc_data_i=0x00100000 on ch0 -> out_valid_o at N+2, dac_data_o=0x00100000, sat_flag_o=0.
- cfg gain ch0=0x0080 (1/32), input 0x100000 -> 0x008000; ch1 gain 0x1000, input 0xF00000 -> dac_data_o=0x00F00000 (PAD_SIGN=0) / 0xFFF00000 (PAD_SIGN=1).
- Gain 0x2000 (2.0): input 0x500000 -> 0x7FFFFF, sat_flag_o[0]=1; input 0x800000 -> 0x800000, flag set; sat_clr_i -> 0.
- Rounding, gain 0x0800 (0.5): input 3 -> 2; input 0xFFFFFD (-3) -> 0xFFFFFF (-1); input 1 -> 1.
- Mute ch1, gain 0x7FFF, input 0x7FFFFF on ch1 -> 0, sat_flag_o[1]=0; ch0 unaffected.
- Channel order: valids with data A,B,C, sync_i with the third, then requests -> reads B(ch1) then... verify C lands in ch0, wrap at NUM_CH=2, same-cycle write/read returns old value.
